// File: rtl/cropper_if.sv
// rtl/cropper_if.sv - video stream bundle between the camera source and the cropper
interface cropper_if;
   logic        pre_vs;
   logic        pre_de;
   logic [23:0] pre_data;
   logic        post_vs;
   logic        post_de;
   logic [23:0] post_data;

   // source side: drives the raw camera stream, observes the cropped stream
   modport master (
      output pre_vs, pre_de, pre_data,
      input  post_vs, post_de, post_data
   );

   // cropper side: consumes the raw stream, produces the cropped stream
   modport slave (
      input  pre_vs, pre_de, pre_data,
      output post_vs, post_de, post_data
   );
endinterface

// File: rtl/cropper.sv
// rtl/cropper.sv - frame-synchronous RGB888 window cropper with shadowed window registers
module cropper #(
   parameter logic [11:0] H_DISP = 12'd1280,
   parameter logic [11:0] V_DISP = 12'd720
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EN,
   input  logic [11:0] x_start,
   input  logic [11:0] x_end,
   input  logic [11:0] y_start,
   input  logic [11:0] y_end,
   cropper_if.slave    vid
);

   localparam logic [0:0] HBLANK = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [11:0] x_cnt_q, x_cnt_d;
   logic [11:0] y_cnt_q, y_cnt_d;
   logic        vs_prev_q;
   logic        en_sh_q, en_sh_d;
   logic [11:0] xs_sh_q, xs_sh_d;
   logic [11:0] xe_sh_q, xe_sh_d;
   logic [11:0] ys_sh_q, ys_sh_d;
   logic [11:0] ye_sh_q, ye_sh_d;
   logic        post_vs_q;
   logic        post_de_q, post_de_d;
   logic [23:0] post_data_q, post_data_d;

   logic        vs_rise;
   logic [11:0] pix_x;
   logic        in_win;

   // Window shadows: latch the live window only at the start of vertical sync
   always_comb begin
      vs_rise = vid.pre_vs & ~vs_prev_q;
      en_sh_d = en_sh_q;
      xs_sh_d = xs_sh_q;
      xe_sh_d = xe_sh_q;
      ys_sh_d = ys_sh_q;
      ye_sh_d = ye_sh_q;
      if (vs_rise) begin
         en_sh_d = EN;
         xs_sh_d = x_start;
         xe_sh_d = x_end;
         ys_sh_d = y_start;
         ye_sh_d = y_end;
      end
   end

   // Line FSM and pixel/line counters; the first pixel of a line always has index 0
   always_comb begin
      state_d = state_q;
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      pix_x   = (state_q == ACTIVE) ? x_cnt_q : 12'd0;
      if (vid.pre_vs) begin
         state_d = HBLANK;
         x_cnt_d = 12'd0;
         y_cnt_d = 12'd0;
      end else if (vid.pre_de) begin
         state_d = ACTIVE;
         x_cnt_d = (pix_x == 12'hFFF) ? pix_x : pix_x + 12'd1;
      end else if (state_q == ACTIVE) begin
         state_d = HBLANK;
         x_cnt_d = 12'd0;
         y_cnt_d = (y_cnt_q == 12'hFFF) ? y_cnt_q : y_cnt_q + 12'd1;
      end
   end

   // Output qualification: vsync overrides everything, EN=0 passes de through
   always_comb begin
      in_win = (pix_x >= xs_sh_q) && (pix_x < xe_sh_q) &&
               (y_cnt_q >= ys_sh_q) && (y_cnt_q < ye_sh_q);
      post_de_d   = ~vid.pre_vs & vid.pre_de & (~en_sh_q | in_win);
      post_data_d = post_de_d ? vid.pre_data : 24'h000000;
   end

   // State, shadow and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HBLANK;
         x_cnt_q     <= 12'd0;
         y_cnt_q     <= 12'd0;
         vs_prev_q   <= 1'b0;
         en_sh_q     <= 1'b0;
         xs_sh_q     <= 12'd0;
         xe_sh_q     <= H_DISP;
         ys_sh_q     <= 12'd0;
         ye_sh_q     <= V_DISP;
         post_vs_q   <= 1'b0;
         post_de_q   <= 1'b0;
         post_data_q <= 24'h000000;
      end else begin
         state_q     <= state_d;
         x_cnt_q     <= x_cnt_d;
         y_cnt_q     <= y_cnt_d;
         vs_prev_q   <= vid.pre_vs;
         en_sh_q     <= en_sh_d;
         xs_sh_q     <= xs_sh_d;
         xe_sh_q     <= xe_sh_d;
         ys_sh_q     <= ys_sh_d;
         ye_sh_q     <= ye_sh_d;
         post_vs_q   <= vid.pre_vs;
         post_de_q   <= post_de_d;
         post_data_q <= post_data_d;
      end
   end

   assign vid.post_vs   = post_vs_q;
   assign vid.post_de   = post_de_q;
   assign vid.post_data = post_data_q;

endmodule

// File: tb/tb_cropper.sv
// tb/tb_cropper.sv - randomized and directed self-checking bench for cropper
module tb_cropper;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [11:0] xs, xe, ys, ye;
   cropper_if   vif ();

   cropper #(.H_DISP(12'd1280), .V_DISP(12'd720)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .EN      (en),
      .x_start (xs),
      .x_end   (xe),
      .y_start (ys),
      .y_end   (ye),
      .vid     (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int de_cnt   = 0;
   logic [23:0] got_q[$];

   // reference model state: frame-level view of the stream
   logic        m_en;
   int          m_xs, m_xe, m_ys, m_ye;
   logic        m_prev_vs;
   logic        m_open;
   int          m_x, m_y;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_xs = 0; m_xe = 1280; m_ys = 0; m_ye = 720;
      m_prev_vs = 1'b0; m_open = 1'b0; m_x = 0; m_y = 0;
   endtask

   task automatic step(input logic vs, input logic de, input logic [23:0] d);
      logic        ed;
      logic [23:0] edat;
      int          x;
      vif.pre_vs = vs; vif.pre_de = de; vif.pre_data = d;
      ed = 1'b0;
      if (vs) begin
         if (!m_prev_vs) begin
            m_en = en; m_xs = xs; m_xe = xe; m_ys = ys; m_ye = ye;
         end
         m_open = 1'b0; m_x = 0; m_y = 0;
      end else if (de) begin
         x = m_open ? m_x : 0;
         ed = m_en ? (x >= m_xs && x < m_xe && m_y >= m_ys && m_y < m_ye) : 1'b1;
         m_x = (x + 1 > 4095) ? 4095 : x + 1;
         m_open = 1'b1;
      end else if (m_open) begin
         m_open = 1'b0; m_x = 0;
         m_y = (m_y + 1 > 4095) ? 4095 : m_y + 1;
      end
      m_prev_vs = vs;
      edat = ed ? d : 24'h000000;
      @(posedge clk); #1;
      chk("post_vs", {23'd0, vif.post_vs}, {23'd0, vs});
      chk("post_de", {23'd0, vif.post_de}, {23'd0, ed});
      chk("post_data", vif.post_data, edat);
      if (vif.post_de) begin
         de_cnt++;
         got_q.push_back(vif.post_data);
      end
   endtask

   task automatic vs_pulse(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom);
      step(1'b0, 1'b0, $urandom);
   endtask

   task automatic line(input int n, input int gap);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, $urandom);
      for (int i = 0; i < gap; i++) step(1'b0, 1'b0, $urandom);
   endtask

   task automatic set_win(input logic e, input int a, input int b, input int c, input int d);
      en = e; xs = 12'(a); xe = 12'(b); ys = 12'(c); ye = 12'(d);
   endtask

   logic [23:0] exp35 [8];

   initial begin
      exp35 = '{24'h12, 24'h13, 24'h14, 24'h15, 24'h22, 24'h23, 24'h24, 24'h25};
      rst_n = 1'b0;
      vif.pre_vs = 1'b0; vif.pre_de = 1'b0; vif.pre_data = 24'h0;
      set_win(1'b0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_post_vs", {23'd0, vif.post_vs}, 24'h0);
      chk("rst_post_de", {23'd0, vif.post_de}, 24'h0);
      chk("rst_post_data", vif.post_data, 24'h0);
      rst_n = 1'b1;

      // reset shadows: EN=0 pass-through before any vsync
      line(5, 2);

      // 4 lines of 8 pixels, window x 2..5, y 1..2
      set_win(1'b1, 2, 6, 1, 3);
      vs_pulse(2);
      got_q.delete();
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 8; x++) step(1'b0, 1'b1, 24'(x + 16 * y));
         step(1'b0, 1'b0, $urandom);
         step(1'b0, 1'b0, $urandom);
      end
      chk("win_count", 24'(got_q.size()), 24'd8);
      for (int i = 0; i < 8; i++)
         if (i < got_q.size()) chk("win_data", got_q[i], exp35[i]);

      // EN=0 pass-through with random de/data
      set_win(1'b0, 3, 5, 0, 1);
      vs_pulse(1);
      for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(0, 1)), $urandom);

      // mid-frame window change takes effect only on the next frame
      set_win(1'b1, 2, 6, 0, 4);
      vs_pulse(2);
      de_cnt = 0;
      line(8, 2);
      xs = 12'd4;
      line(8, 2);
      chk("shadow_hold", 24'(de_cnt), 24'd8);
      vs_pulse(2);
      de_cnt = 0;
      line(8, 2);
      chk("shadow_load", 24'(de_cnt), 24'd2);

      // empty window: nothing for the whole frame
      set_win(1'b1, 6, 6, 0, 4);
      vs_pulse(2);
      de_cnt = 0;
      for (int i = 0; i < 3; i++) line(8, 1);
      chk("empty_win", 24'(de_cnt), 24'd0);

      // async reset during pixel 3 of line 1
      set_win(1'b1, 2, 6, 0, 4);
      vs_pulse(2);
      line(8, 2);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_post_de", {23'd0, vif.post_de}, 24'h0);
      chk("arst_post_data", vif.post_data, 24'h0);
      #1 rst_n = 1'b1;
      model_reset();
      line(4, 2);
      de_cnt = 0;
      line(8, 2);
      chk("arst_pass", 24'(de_cnt), 24'd8);

      // vsync with de held high has priority, pixel 0 follows vs fall
      set_win(1'b1, 0, 4095, 0, 4095);
      step(1'b0, 1'b0, $urandom);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom);
      de_cnt = 0;
      line(10, 2);
      chk("vs_prio_count", 24'(de_cnt), 24'd10);

      // x counter saturation on an over-long line
      set_win(1'b1, 4090, 4095, 0, 1);
      vs_pulse(1);
      de_cnt = 0;
      line(4100, 2);
      chk("x_sat", 24'(de_cnt), 24'd5);

      // random frames: random windows, line lengths and single-cycle gaps
      for (int f = 0; f < 6; f++) begin
         set_win(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 12),
                 $urandom_range(0, 3), $urandom_range(0, 6));
         vs_pulse($urandom_range(1, 3));
         for (int l = 0; l < 7; l++) line($urandom_range(0, 12), $urandom_range(1, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
